// File: rtl/timer_prescaler_if.sv
// Timer prescaler control/status bundle. There is no valid/ready handshake:
// every signal is a level sampled on each rising sysClock edge.
interface timer_prescaler_if #(
    parameter int N_CH = 2
);
    logic [3*N_CH-1:0] cs;
    logic [N_CH-1:0]   ext_pin;
    logic              psr;
    logic [N_CH-1:0]   tick;
    logic [9:0]        presc_count;

    modport master (
        output cs,
        output ext_pin,
        output psr,
        input  tick,
        input  presc_count
    );

    modport slave (
        input  cs,
        input  ext_pin,
        input  psr,
        output tick,
        output presc_count
    );
endinterface

// File: rtl/timer_prescaler.sv
// Shared 10-bit timer prescaler producing one-cycle clock-enable ticks per channel,
// selectable from stop, clk, clk/8/64/256/1024 or a synchronized external pin edge.
module timer_prescaler #(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic               sysClock,
    input logic               rst_n,
    timer_prescaler_if.slave  bus
);
    localparam logic [2:0] CS_STOP  = 3'b000;
    localparam logic [2:0] CS_CLK   = 3'b001;
    localparam logic [2:0] CS_DIV8  = 3'b010;
    localparam logic [2:0] CS_DIV64 = 3'b011;
    localparam logic [2:0] CS_DIV256  = 3'b100;
    localparam logic [2:0] CS_DIV1024 = 3'b101;
    localparam logic [2:0] CS_FALL  = 3'b110;
    localparam logic [2:0] CS_RISE  = 3'b111;

    logic [9:0]      cnt_q;
    logic [N_CH-1:0] tick_d;
    logic [N_CH-1:0] tick_q;
    logic            t8;
    logic            t64;
    logic            t256;
    logic            t1024;

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.psr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    // Taps fire on the last count of each period; psr blanks them so a restart
    // always yields a full first period.
    assign t8    = !bus.psr && (cnt_q[2:0] == 3'd7);
    assign t64   = !bus.psr && (cnt_q[5:0] == 6'd63);
    assign t256  = !bus.psr && (cnt_q[7:0] == 8'd255);
    assign t1024 = !bus.psr && (cnt_q == 10'd1023);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   s;
        logic                   rise;
        logic                   fall;
        logic                   sel;

        always_ff @(posedge sysClock or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_pin[i]};
                prev_q <= s;
            end
        end

        assign s    = sync_q[SYNC_STAGES-1];
        assign rise = s & ~prev_q;
        assign fall = ~s & prev_q;

        always_comb begin
            sel = 1'b0;
            case (bus.cs[3*i +: 3])
                CS_STOP:    sel = 1'b0;
                CS_CLK:     sel = 1'b1;
                CS_DIV8:    sel = t8;
                CS_DIV64:   sel = t64;
                CS_DIV256:  sel = t256;
                CS_DIV1024: sel = t1024;
                CS_FALL:    sel = fall;
                CS_RISE:    sel = rise;
            endcase
        end

        assign tick_d[i] = sel;
    end

    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.presc_count = cnt_q;
endmodule

// File: tb/tb_timer_prescaler.sv
// Bench for timer_prescaler: directed test-plan phases plus randomized traffic,
// checked every cycle against an arithmetic model of counter, taps and pin edges.
module tb_timer_prescaler;
    localparam int N_CH = 2;
    localparam int SYNC = 2;

    logic sysClock = 1'b0;
    logic rst_n    = 1'b0;

    timer_prescaler_if #(.N_CH(N_CH)) bus ();

    timer_prescaler #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .sysClock (sysClock),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 sysClock = ~sysClock;

    int              vectors;
    int              miscompares;
    int              cnt_model;
    logic [N_CH-1:0] exp_tick;
    logic [N_CH-1:0] hist_q[$];

    // Prescaled source fires when the count before the edge ends a period.
    function automatic logic tap(input int period, input int c, input logic psr);
        return !psr && ((c % period) == period - 1);
    endfunction

    task automatic model_reset();
        cnt_model = 0;
        exp_tick  = '0;
        hist_q.delete();
        for (int i = 0; i < SYNC + 2; i++) hist_q.push_front('0);
    endtask

    // hist_q[0] is the pin value sampled at this edge, hist_q[k] at k edges ago.
    task automatic model_edge();
        logic [N_CH-1:0] nt;
        nt = '0;
        hist_q.push_front(bus.ext_pin);
        for (int i = 0; i < N_CH; i++) begin
            case (bus.cs[3*i +: 3])
                3'd0: nt[i] = 1'b0;
                3'd1: nt[i] = 1'b1;
                3'd2: nt[i] = tap(8, cnt_model, bus.psr);
                3'd3: nt[i] = tap(64, cnt_model, bus.psr);
                3'd4: nt[i] = tap(256, cnt_model, bus.psr);
                3'd5: nt[i] = tap(1024, cnt_model, bus.psr);
                3'd6: nt[i] = !hist_q[SYNC][i] && hist_q[SYNC+1][i];
                default: nt[i] = hist_q[SYNC][i] && !hist_q[SYNC+1][i];
            endcase
        end
        void'(hist_q.pop_back());
        exp_tick  = nt;
        cnt_model = bus.psr ? 0 : (cnt_model + 1) % 1024;
    endtask

    task automatic check(input string tag);
        logic [9:0] exp_cnt;
        exp_cnt = 10'(cnt_model);
        vectors++;
        assert (bus.presc_count === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s presc_count: observed %0d expected %0d", tag, bus.presc_count, exp_cnt);
        end
        assert (bus.tick === exp_tick) else begin
            miscompares++;
            $error("FAIL %s tick: observed %b expected %b", tag, bus.tick, exp_tick);
        end
    endtask

    task automatic step(input int n, input string tag);
        repeat (n) begin
            @(posedge sysClock);
            model_edge();
            #1;
            check(tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge sysClock);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag);
        @(negedge sysClock);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.cs      = '0;
        bus.ext_pin = '0;
        bus.psr     = 1'b0;
        model_reset();
        #2;
        check("reset");

        // clk/8 on channel 0, clk/1024 on channel 1
        bus.cs = {3'b101, 3'b010};
        @(negedge sysClock);
        rst_n = 1'b1;
        step(2100, "div8_div1024");

        // every-cycle then stop
        bus.cs = {3'b000, 3'b001};
        apply_reset("reset_clk");
        step(49, "clk");
        bus.cs[2:0] = 3'b000;
        step(20, "stop");

        // clk/64 with a one-cycle psr pulse at edge 40
        bus.cs = {3'b000, 3'b011};
        apply_reset("reset_div64");
        step(39, "div64_pre");
        bus.psr = 1'b1;
        step(1, "psr_pulse");
        bus.psr = 1'b0;
        step(200, "div64_post");

        // external edges, 6-cycle square wave
        bus.cs = {3'b110, 3'b111};
        for (int p = 0; p < 20; p++) begin
            bus.ext_pin = 2'b11;
            step(3, "ext_high");
            bus.ext_pin = 2'b00;
            step(3, "ext_low");
        end

        // select switch onto a static high pin, then one real pulse
        bus.ext_pin = 2'b01;
        bus.cs      = {3'b000, 3'b000};
        step(10, "ext_static");
        bus.cs[2:0] = 3'b111;
        step(10, "ext_switch");
        bus.ext_pin[0] = 1'b0;
        step(3, "ext_drop");
        bus.ext_pin[0] = 1'b1;
        step(10, "ext_rise");

        // asynchronous reset mid-run, then clk/8 restarts from zero
        bus.ext_pin = '0;
        bus.cs      = {3'b001, 3'b010};
        step(37, "pre_async");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        @(negedge sysClock);
        rst_n = 1'b1;
        step(20, "post_async");

        // randomized selects, psr pulses and pin activity
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 63) == 0) bus.cs[3*i +: 3] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) bus.ext_pin[i] = ~bus.ext_pin[i];
            end
            bus.psr = ($urandom_range(0, 15) == 0);
            step(1, "random");
        end
        bus.psr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timer_prescaler.md
# timer_prescaler

Shared timer clock prescaler for the ATMega32A timer blocks, with N_CH independent clock-select channels. It runs one free-running 10-bit prescaler counter and gives each channel a one-cycle clock-enable tick. Per channel, the tick source is stop, clk, clk/8, clk/64, clk/256, clk/1024, or an external-pin edge. Timers clock on sysClock and gate their count with the tick; no derived clocks are produced.

## Interface
- N_CH, default 2: number of timer channels; 1..8.
- SYNC_STAGES, default 2: synchronizer depth for each external pin; 2..4.

- sysClock  in  1  system clock; all flops are rising-edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cs  in  3*N_CH  clock select; channel i uses cs[3i+2:3i].
- ext_pin  in  N_CH  external clock pin for channel i (Tn pin); asynchronous.
- psr  in  1  prescaler reset; synchronous, level-sensitive, active-high.
- tick  out  N_CH  registered clock enable; channel i is 1 for exactly one cycle per source event.
- presc_count  out  10  current prescaler counter value, for debug and verification.

## Operation
- Prescaler counter is 10 bits and shared by all channels.
  - It increments by 1 every cycle and wraps from 1023 to 0.
  - If psr=1, the next value is 0 instead of count+1.
- Tap conditions, evaluated on the current counter value:
  - t8: cnt[2:0]==7
  - t64: cnt[5:0]==63
  - t256: cnt[7:0]==255
  - t1024: cnt==1023
  - All taps are forced to 0 in any cycle where psr=1.
- External path, per channel:
  - ext_pin passes through a SYNC_STAGES flop chain to give s.
  - A further flop holds prev = s from the previous cycle.
  - rise = s & ~prev; fall = ~s & prev.
  - The edge detectors run continuously, whatever cs is set to.
  - psr does not affect the external path.
- Per-channel tick register, next value selected by cs:
  - 000: 0 (stopped)
  - 001: 1 (every cycle)
  - 010: t8
  - 011: t64
  - 100: t256
  - 101: t1024
  - 110: fall
  - 111: rise
- cs changes take effect at the next rising edge.
  - The shared counter is not reset on a cs change, so the first prescaled tick after a switch may come after a partial period.
  - No tick is ever longer than one cycle.
- Channels are fully independent; any mix of cs values is legal.

## Timing
- Reset (rst_n=0), immediately and asynchronously:
  - presc_count=0, tick=0.
  - All synchronizer and prev flops = 0.
- After rst_n rises, counter value after edge k is k (mod 1024).
  - cs=001: tick=1 from edge 1 onward.
  - cs=010: tick is first high after edge 8, then every 8 cycles.
  - cs=011 / 100 / 101: first tick after edge 64 / 256 / 1024, then with that period.
- Latency: a tap condition true at edge n produces tick high during the cycle after edge n, for one cycle.
- psr:
  - Sampled 1 at edge n: counter=0 after edge n, and no prescaled tick follows edge n.
  - If psr is last high at edge n, the clk/8 tick follows edge n+8 (full period).
  - Holding psr high suppresses all prescaled ticks indefinitely.
  - cs=001 and external ticks are unaffected by psr.
- External latency:
  - A pin transition set up before edge k gives a tick after edge k+SYNC_STAGES.
  - Pin pulses of at least 1 cycle high and 1 cycle low are each guaranteed a tick.
  - Shorter pulses may be lost.
- Glitch-free select:
  - Switching cs to 110/111 while the pin is static produces no tick.
  - Reset mid-operation aborts everything; counting resumes from 0.

## Test plan
- Reset release, cs0=010, cs1=101, psr=0, run 2100 cycles -> tick0 pulses after edges 8, 16, 24, …; tick1 pulses after edges 1024 and 2048 only.
- cs0=001 -> tick0=1 every cycle from edge 1; cs0 set to 000 before edge 50 -> tick0=0 after edge 50.
- cs0=011, psr pulsed high for 1 cycle at edge 40 -> no tick at edge 64; next tick after edge 104, then every 64.
- cs0=111, cs1=110, SYNC_STAGES=2, ext_pin[0]=ext_pin[1]=square wave with 6-cycle period -> tick0 2 cycles after each rise, tick1 2 cycles after each fall, one cycle wide; tick count equals edge count.
- ext_pin[0] held 1, cs0 switched 000 -> 111 -> tick0 stays 0; then pin drops and rises -> exactly one tick.
- rst_n asserted mid-run between clock edges -> tick and presc_count go to 0 immediately; after release, cs0=010 ticks first after edge 8.
